// File: rtl/spart_pkg.sv
// Shared definitions for the SPART host-side driver: bus addresses,
// controller state encoding and the ASCII control characters it emits.
package spart_pkg;

  // SPART register map on the ioaddr bus
  localparam logic [1:0] IOADDR_DATA   = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DB_LO  = 2'b10;
  localparam logic [1:0] IOADDR_DB_HI  = 2'b11;

  // ASCII control/separator characters
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Controller states
  typedef enum logic [3:0] {
    ST_INIT_LO = 4'd0,
    ST_INIT_HI = 4'd1,
    ST_IDLE    = 4'd2,
    ST_RX_READ = 4'd3,
    ST_LOAD    = 4'd4,
    ST_DIGIT   = 4'd5,
    ST_SEP     = 4'd6,
    ST_CR      = 4'd7,
    ST_LF      = 4'd8,
    ST_DONE    = 4'd9
  } state_e;

endpackage

// File: rtl/spart_hex_driver_hex2ascii.sv
// Nibble to uppercase ASCII hex digit encoder.
module hex2ascii (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // 0-9 map onto '0'..'9', 10-15 map onto 'A'..'F'
  always_comb begin
    if (nib < 4'd10) ascii = 8'h30 + {4'h0, nib};
    else             ascii = 8'h37 + {4'h0, nib};
  end

endmodule

// File: rtl/spart_hex_driver.sv
// SPART host driver: programs the baud divisor after reset, then prints a
// snapshot of data2output as hex digits (MS nibble first), a separator and
// an optional CR/LF each time it is triggered. Received bytes are returned.
//
// Bus handshake: each cycle with iocs=0 is one SPART access. iorw=0 with
// sel=1 is a write of the byte on databus to ioaddr; iorw=1 at ioaddr=00
// in RX_READ is a read of the received byte. Character writes happen only
// in a cycle where tbr=1, at most one per such cycle; tbr=0 stalls with no
// bus activity.
module spart_hex_driver
  import spart_pkg::*;
#(
  parameter int          DATA_W    = 24,
  parameter int          TRIG_MODE = 0,
  parameter int          LZ_SUPP   = 0,
  parameter logic [7:0]  SEP_CHAR  = ASCII_SPACE,
  parameter int          EOL_EN    = 0,
  parameter logic [15:0] DIV0      = 16'h12C0,
  parameter logic [15:0] DIV1      = 16'h2580,
  parameter logic [15:0] DIV2      = 16'h4B00,
  parameter logic [15:0] DIV3      = 16'h9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        br_cfg,
  input  logic              reinit,
  input  logic              start,
  input  logic [DATA_W-1:0] data2output,
  input  logic              rda,
  input  logic              tbr,
  output logic              iocs,
  output logic              iorw,
  output logic [1:0]        ioaddr,
  inout  wire  [7:0]        databus,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              busy
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  // A width that is not a whole number of nibbles cannot be printed
  generate
    if (DATA_W % 4 != 0) begin : g_bad_width
      $error("spart_hex_driver: DATA_W must be a multiple of 4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               rx_valid_q, rx_valid_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  snap_q, snap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               seen_nz_q, seen_nz_d;

  logic               sel;
  logic [7:0]         wdata;
  logic [15:0]        div_sel;
  logic               trig;
  logic [3:0]         cur_nib;
  logic [7:0]         cur_ascii;

  // Current digit of the snapshot and its ASCII code
  assign cur_nib = snap_q[4*idx_q +: 4];

  hex2ascii u_hex2ascii (
    .nib   (cur_nib),
    .ascii (cur_ascii)
  );

  assign trig    = (TRIG_MODE == 0) ? rda : start;
  assign databus = sel ? wdata : 8'bz;

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

  // Divisor chosen by the baud select input
  always_comb begin
    case (br_cfg)
      2'b00:   div_sel = DIV0;
      2'b01:   div_sel = DIV1;
      2'b10:   div_sel = DIV2;
      default: div_sel = DIV3;
    endcase
  end

  // State and datapath registers; reset aborts any message and reprograms
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT_LO;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      snap_q     <= '0;
      idx_q      <= '0;
      seen_nz_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      seen_nz_q  <= seen_nz_d;
    end
  end

  // Next-state, datapath updates and bus outputs
  always_comb begin
    state_d    = state_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    seen_nz_d  = seen_nz_q;
    iocs       = 1'b1;
    iorw       = 1'b1;
    ioaddr     = IOADDR_DATA;
    sel        = 1'b0;
    wdata      = 8'h00;

    case (state_q)
      ST_INIT_LO: begin
        iocs    = 1'b0;
        iorw    = 1'b0;
        ioaddr  = IOADDR_DB_LO;
        sel     = 1'b1;
        wdata   = div_sel[7:0];
        state_d = ST_INIT_HI;
      end

      ST_INIT_HI: begin
        iocs    = 1'b0;
        iorw    = 1'b0;
        ioaddr  = IOADDR_DB_HI;
        sel     = 1'b1;
        wdata   = div_sel[15:8];
        state_d = ST_IDLE;
      end

      ST_IDLE: begin
        iocs = 1'b0;
        if (reinit) begin
          state_d = ST_INIT_LO;
        end else if (trig) begin
          state_d = (TRIG_MODE == 0) ? ST_RX_READ : ST_LOAD;
        end
      end

      ST_RX_READ: begin
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = IOADDR_DATA;
        rx_byte_d  = databus;
        rx_valid_d = 1'b1;
        state_d    = ST_LOAD;
      end

      ST_LOAD: begin
        snap_d    = data2output;
        idx_d     = IDX_W'(NIB - 1);
        busy_d    = 1'b1;
        seen_nz_d = 1'b0;
        state_d   = ST_DIGIT;
      end

      ST_DIGIT: begin
        if (tbr) begin
          if ((LZ_SUPP != 0) && (cur_nib == 4'h0) && (idx_q != '0) && !seen_nz_q) begin
            idx_d = idx_q - 1'b1;
          end else begin
            iocs      = 1'b0;
            iorw      = 1'b0;
            ioaddr    = IOADDR_DATA;
            sel       = 1'b1;
            wdata     = cur_ascii;
            seen_nz_d = 1'b1;
            if (idx_q == '0) state_d = ST_SEP;
            else             idx_d   = idx_q - 1'b1;
          end
        end
      end

      ST_SEP: begin
        if (tbr) begin
          iocs    = 1'b0;
          iorw    = 1'b0;
          sel     = 1'b1;
          wdata   = SEP_CHAR;
          state_d = (EOL_EN != 0) ? ST_CR : ST_DONE;
        end
      end

      ST_CR: begin
        if (tbr) begin
          iocs    = 1'b0;
          iorw    = 1'b0;
          sel     = 1'b1;
          wdata   = ASCII_CR;
          state_d = ST_LF;
        end
      end

      ST_LF: begin
        if (tbr) begin
          iocs    = 1'b0;
          iorw    = 1'b0;
          sel     = 1'b1;
          wdata   = ASCII_LF;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_INIT_LO;
    endcase
  end

endmodule

// File: tb/tb_spart_hex_driver.sv
// Bench for spart_hex_driver: three configurations share clock, reset,
// br_cfg and tbr. Every write on each bus is captured as {ioaddr, byte}
// and compared against hand-computed expected sequences.
module tb_spart_hex_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] br_cfg = 2'b01;
  logic       tbr    = 1'b1;
  logic [7:0] rx_val = 8'h00;

  // instance 0: DATA_W=24, rda trigger
  logic        reinit0 = 1'b0, rda0 = 1'b0;
  logic [23:0] data0   = '0;
  logic        iocs0, iorw0, rx_valid0, busy0;
  logic [1:0]  ioaddr0;
  logic [7:0]  rx_byte0;
  wire  [7:0]  db0;
  assign db0 = iorw0 ? rx_val : 8'bz;

  // instance 1: DATA_W=24, start trigger, leading-zero suppression
  logic        start1 = 1'b0;
  logic [23:0] data1  = '0;
  logic        iocs1, iorw1, rx_valid1, busy1;
  logic [1:0]  ioaddr1;
  logic [7:0]  rx_byte1;
  wire  [7:0]  db1;
  assign db1 = iorw1 ? rx_val : 8'bz;

  // instance 2: DATA_W=8, start trigger, CR/LF enabled
  logic        start2 = 1'b0;
  logic [7:0]  data2  = '0;
  logic        iocs2, iorw2, rx_valid2, busy2;
  logic [1:0]  ioaddr2;
  logic [7:0]  rx_byte2;
  wire  [7:0]  db2;
  assign db2 = iorw2 ? rx_val : 8'bz;

  spart_hex_driver #(.DATA_W(24), .TRIG_MODE(0)) u0 (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .reinit(reinit0), .start(1'b0),
    .data2output(data0), .rda(rda0), .tbr(tbr), .iocs(iocs0), .iorw(iorw0),
    .ioaddr(ioaddr0), .databus(db0), .rx_byte(rx_byte0), .rx_valid(rx_valid0),
    .busy(busy0));

  spart_hex_driver #(.DATA_W(24), .TRIG_MODE(1), .LZ_SUPP(1)) u1 (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .reinit(1'b0), .start(start1),
    .data2output(data1), .rda(1'b0), .tbr(tbr), .iocs(iocs1), .iorw(iorw1),
    .ioaddr(ioaddr1), .databus(db1), .rx_byte(rx_byte1), .rx_valid(rx_valid1),
    .busy(busy1));

  spart_hex_driver #(.DATA_W(8), .TRIG_MODE(1), .EOL_EN(1)) u2 (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .reinit(1'b0), .start(start2),
    .data2output(data2), .rda(1'b0), .tbr(tbr), .iocs(iocs2), .iorw(iorw2),
    .ioaddr(ioaddr2), .databus(db2), .rx_byte(rx_byte2), .rx_valid(rx_valid2),
    .busy(busy2));

  // ---------------- bus monitors ----------------
  logic [9:0] q0[$], q1[$], q2[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (!iocs0 && !iorw0) q0.push_back({ioaddr0, db0});
      if (!iocs1 && !iorw1) q1.push_back({ioaddr1, db1});
      if (!iocs2 && !iorw2) q2.push_back({ioaddr2, db2});
    end
  end

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(logic [63:0] bytes, int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'b00, bytes[63-8*k -: 8]});
  endtask

  task automatic compare_q(int inst, string name);
    logic [9:0] got[$];
    int n;
    case (inst)
      0:       got = q0;
      1:       got = q1;
      default: got = q2;
    endcase
    check($sformatf("%s_len", name), got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s_b%0d", name, k), {22'd0, got[k]}, {22'd0, exp_q[k]});
    exp_q.delete();
    case (inst)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic logic get_busy(int inst);
    case (inst)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_rx_valid(string name, int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (rx_valid0) seen = 1;
    end
    if (!seen) fail_timeout(name);
  endtask

  task automatic trigger(int inst, logic [23:0] d, logic [7:0] rxv);
    case (inst)
      0: begin
        data0  = d;
        rx_val = rxv;
        rda0   = 1'b1;
        wait_rx_valid("rx_valid", 20);
        tick();
        rda0 = 1'b0;
      end
      1: begin
        data1  = d;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
      end
      default: begin
        data2  = d[7:0];
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
      end
    endcase
  endtask

  task automatic wait_done(int inst, string name);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (get_busy(inst)) seen = 1;
    end
    if (!seen) fail_timeout({name, "_busy_rise"});
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (!get_busy(inst)) seen = 1;
    end
    if (!seen) fail_timeout({name, "_busy_fall"});
    tick();
    tick();
  endtask

  task automatic wait_q0(int n, string name);
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (q0.size() >= n) seen = 1;
    end
    if (!seen) fail_timeout(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          inst;
    logic [23:0] data;
    int          n;
    logic [63:0] bytes;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_before;

    vecs[0] = '{0, 24'h1A2B3C, 7, 64'h3141_3242_3343_2000};
    vecs[1] = '{0, 24'h09F0A5, 7, 64'h3039_4630_4135_2000};
    vecs[2] = '{1, 24'h00000F, 2, 64'h4620_0000_0000_0000};
    vecs[3] = '{1, 24'h000000, 2, 64'h3020_0000_0000_0000};
    vecs[4] = '{1, 24'h0100A0, 6, 64'h3130_3041_3020_0000};
    vecs[5] = '{2, 24'h0000FF, 5, 64'h4646_200D_0A00_0000};
    vecs[6] = '{2, 24'h00003C, 5, 64'h3343_200D_0A00_0000};

    // ---- reset ----
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy",     {31'd0, busy0},     32'd0);
    check("rst_rx_valid", {31'd0, rx_valid0}, 32'd0);
    check("rst_rx_byte",  {24'd0, rx_byte0},  32'd0);
    check("rst_ioaddr",   {30'd0, ioaddr0},   32'd2);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("idle_iocs", {31'd0, iocs0}, 32'd0);
    check("idle_iorw", {31'd0, iorw0}, 32'd1);
    exp_q.push_back({2'b10, 8'h80});
    exp_q.push_back({2'b11, 8'h25});
    compare_q(0, "init0");
    exp_q.push_back({2'b10, 8'h80});
    exp_q.push_back({2'b11, 8'h25});
    compare_q(1, "init1");
    exp_q.push_back({2'b10, 8'h80});
    exp_q.push_back({2'b11, 8'h25});
    compare_q(2, "init2");
    tick();

    // ---- table-driven messages ----
    for (int i = 0; i < 7; i++) begin
      trigger(vecs[i].inst, vecs[i].data, 8'h40 + 8'(i));
      wait_done(vecs[i].inst, $sformatf("vec%0d", i));
      push_msg(vecs[i].bytes, vecs[i].n);
      compare_q(vecs[i].inst, $sformatf("vec%0d", i));
      if (vecs[i].inst == 0)
        check($sformatf("vec%0d_rx_byte", i), {24'd0, rx_byte0}, {24'd0, 8'h40 + 8'(i)});
    end

    // ---- tbr stall with data change mid-message ----
    trigger(0, 24'h123456, 8'h11);
    wait_q0(2, "stall_start");
    tick();
    tbr = 1'b0;
    n_before = q0.size();
    data0 = 24'hFFFFFF;
    repeat (10) tick();
    check("stall_no_writes", q0.size(), n_before);
    check("stall_busy", {31'd0, busy0}, 32'd1);
    tbr = 1'b1;
    wait_done(0, "stall");
    push_msg(64'h3132_3334_3536_2000, 7);
    compare_q(0, "stall");

    // ---- rda while busy is serviced after DONE ----
    trigger(0, 24'hABCDEF, 8'h22);
    repeat (3) tick();
    rx_val = 8'h5A;
    rda0   = 1'b1;
    wait_rx_valid("rda_pending", 200);
    tick();
    rda0 = 1'b0;
    wait_done(0, "rda_pending");
    push_msg(64'h4142_4344_4546_2000, 7);
    push_msg(64'h4142_4344_4546_2000, 7);
    compare_q(0, "rda_pending");
    check("rda_pending_rx_byte", {24'd0, rx_byte0}, 32'h5A);

    // ---- reinit and rda in the same IDLE cycle ----
    br_cfg = 2'b11;
    data0  = 24'h000001;
    rx_val = 8'h33;
    reinit0 = 1'b1;
    rda0    = 1'b1;
    tick();
    reinit0 = 1'b0;
    wait_rx_valid("reinit_rda", 20);
    tick();
    rda0 = 1'b0;
    wait_done(0, "reinit_rda");
    exp_q.push_back({2'b10, 8'h00});
    exp_q.push_back({2'b11, 8'h96});
    push_msg(64'h3030_3030_3031_2000, 7);
    compare_q(0, "reinit_rda");

    // ---- reset mid-digit aborts and reprograms ----
    br_cfg = 2'b10;
    trigger(0, 24'h777777, 8'h44);
    wait_q0(3, "rst_mid_start");
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_ioaddr", {30'd0, ioaddr0}, 32'd2);
    check("rst_mid_iorw",   {31'd0, iorw0},   32'd0);
    check("rst_mid_busy",   {31'd0, busy0},   32'd0);
    check("rst_mid_db",     {24'd0, db0},     32'h00);
    check("rst_mid_rx_byte", {24'd0, rx_byte0}, 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    exp_q.push_back({2'b10, 8'h00});
    exp_q.push_back({2'b11, 8'h4B});
    compare_q(0, "rst_mid_reinit");
    check("rst_mid_idle_busy", {31'd0, busy0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
